// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_pkg
//  Description : Shared types and constants for the HD44780 LCD driver:
//                controller state encoding, power-up init sequence bytes,
//                long-execution (clear/home) opcodes and small constant
//                helper functions used to size the wait counter.
//  Revision    : 1.0  initial release
// ============================================================================
package lcd_pkg;

    // Controller states, explicit 3-bit encoding
    typedef enum logic [2:0] {
        ST_PWR_WAIT = 3'd0,
        ST_IDLE     = 3'd1,
        ST_SETUP    = 3'd2,
        ST_ENABLE   = 3'd3,
        ST_HOLD     = 3'd4,
        ST_EXEC     = 3'd5
    } lcd_state_t;

    // Power-up init sequence, issued with RS=0 in this order
    localparam logic [7:0] c_INIT_FUNC_SET = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
    localparam logic [7:0] c_INIT_DISP_ON  = 8'h0C;  // display on, cursor off
    localparam logic [7:0] c_INIT_CLEAR    = 8'h01;  // clear display
    localparam logic [7:0] c_INIT_ENTRY    = 8'h06;  // increment, no shift

    // Instructions that need the long execute wait (RS=0 only)
    localparam logic [7:0] c_OP_CLEAR      = 8'h01;
    localparam logic [7:0] c_OP_HOME       = 8'h02;
    localparam logic [7:0] c_OP_HOME_ALT   = 8'h03;  // home, low bit is don't-care

    function automatic logic [7:0] init_byte(input logic [1:0] idx);
        logic [7:0] v;
        case (idx)
            2'd0:    v = c_INIT_FUNC_SET;
            2'd1:    v = c_INIT_DISP_ON;
            2'd2:    v = c_INIT_CLEAR;
            default: v = c_INIT_ENTRY;
        endcase
        return v;
    endfunction

    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return !rs && ((data == c_OP_CLEAR) || (data == c_OP_HOME) ||
                       (data == c_OP_HOME_ALT));
    endfunction

    // A zero-length wait still has to occupy one cycle of its state
    function automatic int unsigned at_least_one(input int unsigned v);
        return (v == 0) ? 1 : v;
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_timer.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_timer
//  Description : Loadable down-counter shared by every wait of the LCD
//                driver. Loading value N-1 makes o_done assert in the N-th
//                cycle after the load, so a state guarded by o_done lasts
//                exactly N cycles.
//  Ports       : clk        clock
//                rst        synchronous active-high reset (loads RST_VAL)
//                i_load     load i_load_val this cycle
//                i_load_val value to load
//                o_done     count has reached zero
//  Revision    : 1.0  initial release
// ============================================================================
module lcd_timer #(
    parameter int unsigned      WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic             o_done
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= RST_VAL;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_done = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/lcd_driver.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_driver
//  Description : Write-only HD44780 driver behind a 32-bit CPU register.
//                Waits out panel power-up, runs the init sequence, then
//                issues one command per toggle of the GO bit with
//                setup / enable / hold / execute timing. One command can be
//                queued; further toggles while it waits are dropped.
//  Ports       : clk_i       clock, rising edge
//                rst_i       synchronous active-high reset
//                io_lcd_i    [31] ON, [10] RS, [8] GO toggle, [7:0] DATA
//                lcd_on_o    panel power/backlight
//                lcd_en_o    enable strobe
//                lcd_rs_o    register select
//                lcd_rw_o    read/write, tied to write
//                lcd_data_o  data bus
//                busy_o      initialising, transferring or command queued
//                overrun_o   one-cycle pulse when a command is dropped
//  Revision    : 1.0  initial release
// ============================================================================
module lcd_driver
    import lcd_pkg::*;
#(
    parameter int unsigned T_PWR   = 750000,
    parameter int unsigned T_SETUP = 2,
    parameter int unsigned T_EN    = 12,
    parameter int unsigned T_HOLD  = 2,
    parameter int unsigned T_EXEC  = 1850,
    parameter int unsigned T_CLEAR = 76000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] io_lcd_i,
    output logic        lcd_on_o,
    output logic        lcd_en_o,
    output logic        lcd_rs_o,
    output logic        lcd_rw_o,
    output logic [7:0]  lcd_data_o,
    output logic        busy_o,
    output logic        overrun_o
);

    localparam int unsigned c_N_PWR   = at_least_one(T_PWR);
    localparam int unsigned c_N_SETUP = at_least_one(T_SETUP);
    localparam int unsigned c_N_EN    = at_least_one(T_EN);
    localparam int unsigned c_N_HOLD  = at_least_one(T_HOLD);
    localparam int unsigned c_N_EXEC  = at_least_one(T_EXEC);
    localparam int unsigned c_N_CLEAR = at_least_one(T_CLEAR);
    localparam int unsigned c_N_MAX   = max_u(max_u(max_u(c_N_PWR, c_N_SETUP),
                                                    max_u(c_N_EN, c_N_HOLD)),
                                              max_u(c_N_EXEC, c_N_CLEAR));
    // Counter holds N-1 at most, so clog2(N) bits are enough
    localparam int          c_CNT_W   = (c_N_MAX > 1) ? $clog2(c_N_MAX) : 1;

    localparam logic [c_CNT_W-1:0] c_LD_PWR   = c_CNT_W'(c_N_PWR   - 1);
    localparam logic [c_CNT_W-1:0] c_LD_SETUP = c_CNT_W'(c_N_SETUP - 1);
    localparam logic [c_CNT_W-1:0] c_LD_EN    = c_CNT_W'(c_N_EN    - 1);
    localparam logic [c_CNT_W-1:0] c_LD_HOLD  = c_CNT_W'(c_N_HOLD  - 1);
    localparam logic [c_CNT_W-1:0] c_LD_EXEC  = c_CNT_W'(c_N_EXEC  - 1);
    localparam logic [c_CNT_W-1:0] c_LD_CLEAR = c_CNT_W'(c_N_CLEAR - 1);

    lcd_state_t         r_state;
    lcd_state_t         w_state_nxt;

    logic               r_rs;
    logic [7:0]         r_data;
    logic               r_en;
    logic               r_busy;
    logic               r_overrun;
    logic               r_on;
    logic               r_go_prev;
    logic               r_pend_valid;
    logic               r_pend_rs;
    logic [7:0]         r_pend_data;
    logic [1:0]         r_init_idx;
    logic               r_in_init;

    logic               w_rs_nxt;
    logic [7:0]         w_data_nxt;
    logic [1:0]         w_init_idx_nxt;
    logic               w_in_init_nxt;
    logic               w_pop;
    logic               w_detect;
    logic               w_capture;
    logic               w_pend_valid_nxt;
    logic               w_overrun_nxt;
    logic               w_tmr_load;
    logic [c_CNT_W-1:0] w_tmr_val;
    logic               w_tmr_done;
    logic               w_unused_bits;

    assign w_unused_bits = ^{io_lcd_i[30:11], io_lcd_i[9]};

    lcd_timer #(
        .WIDTH   (c_CNT_W),
        .RST_VAL (c_LD_PWR)
    ) u_timer (
        .clk        (clk_i),
        .rst        (rst_i),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_done     (w_tmr_done)
    );

    // ------------------------------------------------------------------
    // Next state, timer reload and output-register loads
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_tmr_load     = 1'b0;
        w_tmr_val      = c_LD_PWR;
        w_pop          = 1'b0;
        w_rs_nxt       = r_rs;
        w_data_nxt     = r_data;
        w_init_idx_nxt = r_init_idx;
        w_in_init_nxt  = r_in_init;

        case (r_state)
            ST_PWR_WAIT: begin
                if (w_tmr_done) begin
                    w_state_nxt    = ST_SETUP;
                    w_tmr_load     = 1'b1;
                    w_tmr_val      = c_LD_SETUP;
                    w_rs_nxt       = 1'b0;
                    w_data_nxt     = init_byte(2'd0);
                    w_init_idx_nxt = 2'd0;
                    w_in_init_nxt  = 1'b1;
                end
            end
            ST_IDLE: begin
                if (r_pend_valid) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_SETUP;
                    w_tmr_load  = 1'b1;
                    w_tmr_val   = c_LD_SETUP;
                    w_rs_nxt    = r_pend_rs;
                    w_data_nxt  = r_pend_data;
                end
            end
            ST_SETUP: begin
                if (w_tmr_done) begin
                    w_state_nxt = ST_ENABLE;
                    w_tmr_load  = 1'b1;
                    w_tmr_val   = c_LD_EN;
                end
            end
            ST_ENABLE: begin
                if (w_tmr_done) begin
                    w_state_nxt = ST_HOLD;
                    w_tmr_load  = 1'b1;
                    w_tmr_val   = c_LD_HOLD;
                end
            end
            ST_HOLD: begin
                if (w_tmr_done) begin
                    w_state_nxt = ST_EXEC;
                    w_tmr_load  = 1'b1;
                    w_tmr_val   = is_long_cmd(r_rs, r_data) ? c_LD_CLEAR : c_LD_EXEC;
                end
            end
            ST_EXEC: begin
                if (w_tmr_done) begin
                    if (r_in_init && (r_init_idx != 2'd3)) begin
                        // Init steps chain straight into the next SETUP
                        w_state_nxt    = ST_SETUP;
                        w_tmr_load     = 1'b1;
                        w_tmr_val      = c_LD_SETUP;
                        w_rs_nxt       = 1'b0;
                        w_data_nxt     = init_byte(r_init_idx + 2'd1);
                        w_init_idx_nxt = r_init_idx + 2'd1;
                    end else begin
                        w_state_nxt   = ST_IDLE;
                        w_in_init_nxt = 1'b0;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_PWR_WAIT;
                w_tmr_load  = 1'b1;
                w_tmr_val   = c_LD_PWR;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // GO-toggle detection and the single pending slot. A pop in the same
    // cycle frees the slot, so a simultaneous detection is kept.
    // ------------------------------------------------------------------
    always_comb begin
        w_detect         = io_lcd_i[8] ^ r_go_prev;
        w_pend_valid_nxt = r_pend_valid & ~w_pop;
        w_capture        = 1'b0;
        w_overrun_nxt    = 1'b0;
        if (w_detect) begin
            if (w_pend_valid_nxt) begin
                w_overrun_nxt = 1'b1;
            end else begin
                w_capture        = 1'b1;
                w_pend_valid_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_PWR_WAIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Outputs are registered from next-state values so each output flop
    // matches the state it belongs to, with no decode glitch on EN.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rs         <= 1'b0;
            r_data       <= 8'h00;
            r_en         <= 1'b0;
            r_busy       <= 1'b1;
            r_overrun    <= 1'b0;
            r_on         <= 1'b0;
            r_go_prev    <= 1'b0;
            r_pend_valid <= 1'b0;
            r_pend_rs    <= 1'b0;
            r_pend_data  <= 8'h00;
            r_init_idx   <= 2'd0;
            r_in_init    <= 1'b0;
        end else begin
            r_rs         <= w_rs_nxt;
            r_data       <= w_data_nxt;
            r_en         <= (w_state_nxt == ST_ENABLE);
            r_busy       <= !((w_state_nxt == ST_IDLE) && !w_pend_valid_nxt);
            r_overrun    <= w_overrun_nxt;
            r_on         <= io_lcd_i[31];
            r_go_prev    <= io_lcd_i[8];
            r_pend_valid <= w_pend_valid_nxt;
            r_init_idx   <= w_init_idx_nxt;
            r_in_init    <= w_in_init_nxt;
            if (w_capture) begin
                r_pend_rs   <= io_lcd_i[10];
                r_pend_data <= io_lcd_i[7:0];
            end
        end
    end

    assign lcd_on_o   = r_on;
    assign lcd_en_o   = r_en;
    assign lcd_rs_o   = r_rs;
    assign lcd_rw_o   = 1'b0;
    assign lcd_data_o = r_data;
    assign busy_o     = r_busy;
    assign overrun_o  = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_lcd_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lcd_driver
//  Description : Self-checking bench for lcd_driver. A timeline model keeps
//                a schedule of transfers (start cycle, RS, DATA) and the
//                cycle the driver becomes free; expected EN/RS/DATA/busy/
//                overrun/on values for every cycle are derived from it.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_lcd_driver;

    localparam int T_PWR   = 10;
    localparam int T_SETUP = 1;
    localparam int T_EN    = 2;
    localparam int T_HOLD  = 1;
    localparam int T_EXEC  = 5;
    localparam int T_CLEAR = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] lcd_in = 32'h0;
    logic        lcd_on, lcd_en, lcd_rs, lcd_rw, lcd_busy, lcd_ovr;
    logic [7:0]  lcd_data;

    lcd_driver #(
        .T_PWR(T_PWR), .T_SETUP(T_SETUP), .T_EN(T_EN),
        .T_HOLD(T_HOLD), .T_EXEC(T_EXEC), .T_CLEAR(T_CLEAR)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .io_lcd_i   (lcd_in),
        .lcd_on_o   (lcd_on),
        .lcd_en_o   (lcd_en),
        .lcd_rs_o   (lcd_rs),
        .lcd_rw_o   (lcd_rw),
        .lcd_data_o (lcd_data),
        .busy_o     (lcd_busy),
        .overrun_o  (lcd_ovr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_value(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: schedule of transfers on a cycle timeline
    // ------------------------------------------------------------------
    typedef struct {
        int         start;  // first SETUP cycle
        bit         rs;
        bit [7:0]   data;
    } xfer_t;

    xfer_t    sched[$];
    int       cyc = 0;
    int       free_at = 0;
    bit       m_go_prev, m_pend_v, m_pend_rs, m_ovr, m_on, m_det, m_pop;
    bit [7:0] m_pend_data;

    function automatic int xfer_len(bit rs, bit [7:0] d);
        bit long_cmd = !rs && (d >= 8'h01) && (d <= 8'h03);
        return T_SETUP + T_EN + T_HOLD + (long_cmd ? T_CLEAR : T_EXEC);
    endfunction

    function automatic bit [7:0] init_val(int i);
        case (i)
            0:       return 8'h38;
            1:       return 8'h0C;
            2:       return 8'h01;
            default: return 8'h06;
        endcase
    endfunction

    task automatic add_xfer(int s, bit rs, bit [7:0] d);
        xfer_t x;
        x.start = s; x.rs = rs; x.data = d;
        sched.push_back(x);
    endtask

    task automatic model_reset(int base);
        int s = base + T_PWR;
        sched.delete();
        for (int i = 0; i < 4; i++) begin
            add_xfer(s, 1'b0, init_val(i));
            s += xfer_len(1'b0, init_val(i));
        end
        free_at   = s;
        m_go_prev = 1'b0;
        m_pend_v  = 1'b0;
        m_ovr     = 1'b0;
        m_on      = 1'b0;
    endtask

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            model_reset(cyc);
        end else begin
            m_det     = (lcd_in[8] != m_go_prev);
            m_go_prev = lcd_in[8];
            m_pop     = (cyc - 1 >= free_at) && m_pend_v;
            m_ovr     = m_det && m_pend_v && !m_pop;
            if (m_pop) begin
                add_xfer(cyc, m_pend_rs, m_pend_data);
                free_at = cyc + xfer_len(m_pend_rs, m_pend_data);
            end
            if (m_det && (!m_pend_v || m_pop)) begin
                m_pend_v    = 1'b1;
                m_pend_rs   = lcd_in[10];
                m_pend_data = lcd_in[7:0];
            end else if (m_pop) begin
                m_pend_v = 1'b0;
            end
            m_on = lcd_in[31];
            if (sched.size() > 8) void'(sched.pop_front());
        end
    end

    function automatic bit exp_en();
        foreach (sched[i])
            if (cyc >= sched[i].start + T_SETUP && cyc < sched[i].start + T_SETUP + T_EN)
                return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit [8:0] exp_rs_data();
        bit [8:0] v = 9'h0;
        foreach (sched[i])
            if (sched[i].start <= cyc) v = {sched[i].rs, sched[i].data};
        return v;
    endfunction

    // ------------------------------------------------------------------
    // Per-cycle checking and EN-pulse monitor
    // ------------------------------------------------------------------
    bit [7:0] seen[$];
    int       seen_cyc[$];
    bit       prev_en = 1'b0;
    int       ovr_cnt = 0;

    task automatic step();
        bit [8:0] rd;
        @(negedge clk);
        rd = exp_rs_data();
        check_value("en",      lcd_en,   exp_en());
        check_value("rs",      lcd_rs,   rd[8]);
        check_value("data",    lcd_data, rd[7:0]);
        check_value("rw",      lcd_rw,   1'b0);
        check_value("busy",    lcd_busy, !((cyc >= free_at) && !m_pend_v));
        check_value("overrun", lcd_ovr,  m_ovr);
        check_value("on",      lcd_on,   m_on);
        if (lcd_en && !prev_en) begin
            seen.push_back(lcd_data);
            seen_cyc.push_back(cyc);
        end
        prev_en = lcd_en;
        if (lcd_ovr) ovr_cnt++;
    endtask

    task automatic send(bit rs, bit [7:0] d);
        lcd_in[10]  = rs;
        lcd_in[7:0] = d;
        lcd_in[8]   = ~lcd_in[8];
    endtask

    task automatic wait_idle(int budget);
        int n = 0;
        step();
        while (lcd_busy && n < budget) begin
            step();
            n++;
        end
        check_value("idle_timeout", lcd_busy, 1'b0);
    endtask

    initial begin
        bit [7:0] long_ops [4];
        bit [31:0] r;
        int n;
        long_ops[0] = 8'h01; long_ops[1] = 8'h02; long_ops[2] = 8'h03; long_ops[3] = 8'h04;

        // Reset with ON requested; power-up, command queued during PWR_WAIT
        lcd_in = 32'h8000_0000;
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        repeat (3) step();
        send(1'b1, 8'h55);
        step();
        lcd_in[10] = 1'b0; lcd_in[7:0] = 8'hFF;
        wait_idle(400);
        check_value("init_count", seen.size(), 5);
        if (seen.size() >= 5) begin
            check_value("init0", seen[0], 8'h38);
            check_value("init1", seen[1], 8'h0C);
            check_value("init2", seen[2], 8'h01);
            check_value("init3", seen[3], 8'h06);
            check_value("queued_pwr", seen[4], 8'h55);
            check_value("clear_gap", seen_cyc[3] - seen_cyc[2],
                        T_EN + T_HOLD + T_CLEAR + T_SETUP);
        end

        // Single data write
        repeat (4) step();
        send(1'b1, 8'h41);
        wait_idle(200);

        // Three back-to-back toggles: first runs, second queued, third dropped
        repeat (3) step();
        seen.delete(); seen_cyc.delete(); ovr_cnt = 0;
        send(1'b0, 8'h80); step();
        send(1'b1, 8'h42); step();
        send(1'b1, 8'h43);
        wait_idle(200);
        check_value("burst_count", seen.size(), 2);
        if (seen.size() == 2) begin
            check_value("burst0", seen[0], 8'h80);
            check_value("burst1", seen[1], 8'h42);
        end
        check_value("burst_ovr", ovr_cnt, 1);

        // Clear/home opcodes and their RS=1 counterparts
        foreach (long_ops[i]) begin
            send(1'b0, long_ops[i]); wait_idle(200);
            send(1'b1, long_ops[i]); wait_idle(200);
        end

        // Randomized register traffic
        repeat (3000) begin
            r = $urandom;
            r[8] = ($urandom_range(0, 7) == 0) ? ~lcd_in[8] : lcd_in[8];
            r[7:0] = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 4)) : 8'($urandom);
            lcd_in = r;
            step();
        end
        wait_idle(300);

        // Reset while EN is high
        send(1'b1, 8'h33);
        n = 0;
        step();
        while (!lcd_en && n < 50) begin
            step();
            n++;
        end
        check_value("reach_enable", lcd_en, 1'b1);
        rst = 1'b1;
        seen.delete(); seen_cyc.delete();
        step();
        check_value("rst_en_low", lcd_en, 1'b0);
        check_value("rst_busy", lcd_busy, 1'b1);
        rst = 1'b0;
        wait_idle(400);
        check_value("reinit_count", seen.size() >= 4, 1'b1);
        if (seen.size() >= 4) begin
            check_value("reinit0", seen[0], 8'h38);
            check_value("reinit3", seen[3], 8'h06);
        end
        repeat (5) step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
